// File: rtl/byte_bus_memory_if.sv
// rtl/byte_bus_memory_if.sv - byte bus, loader and debug signals between core side and memory endpoint
interface byte_bus_memory_if;
    logic        bus_pc;
    logic        bus_mar;
    logic        bus_mdr;
    logic        halt;
    logic [7:0]  out_bus;
    logic [7:0]  in_bus;
    logic        ard_data_ready;
    logic        ard_receive_ready;
    logic        prog_we;
    logic [15:0] prog_addr;
    logic [15:0] prog_data;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_data;
    logic        halted;

    modport master (
        output bus_pc, bus_mar, bus_mdr, halt, out_bus,
        output prog_we, prog_addr, prog_data, dbg_addr,
        input  in_bus, ard_data_ready, ard_receive_ready, dbg_data, halted
    );

    modport slave (
        input  bus_pc, bus_mar, bus_mdr, halt, out_bus,
        input  prog_we, prog_addr, prog_data, dbg_addr,
        output in_bus, ard_data_ready, ard_receive_ready, dbg_data, halted
    );
endinterface

// File: rtl/byte_bus_memory.sv
// rtl/byte_bus_memory.sv - memory endpoint serving fetch/load/store over the core's 8-bit byte bus
module byte_bus_memory #(
    parameter int         IMEM_DEPTH  = 16,
    parameter int         DMEM_DEPTH  = 16,
    parameter logic [3:0] I_TYPE_CODE = 4'h1,
    parameter logic [3:0] M_TYPE_CODE = 4'h2
) (
    input logic              clk,
    input logic              rst,
    byte_bus_memory_if.slave bus
);
    // Depths are powers of two, so the low index bits are the address modulo depth.
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_PC_HI   = 4'd1;
    localparam logic [3:0] S_F0L     = 4'd2;
    localparam logic [3:0] S_F0H     = 4'd3;
    localparam logic [3:0] S_F1L     = 4'd4;
    localparam logic [3:0] S_F1H     = 4'd5;
    localparam logic [3:0] S_A_HI    = 4'd6;
    localparam logic [3:0] S_R_L     = 4'd7;
    localparam logic [3:0] S_R_H     = 4'd8;
    localparam logic [3:0] S_W_L     = 4'd9;
    localparam logic [3:0] S_W_H     = 4'd10;
    localparam logic [3:0] S_RECOVER = 4'd11;
    localparam logic [3:0] S_HALTED  = 4'd12;

    logic [3:0]    state_q, state_d;
    logic [15:0]   pc_q, addr_q;
    logic [7:0]    lo_q;
    logic [15:0]   imem [IMEM_DEPTH];
    logic [15:0]   dmem [DMEM_DEPTH];
    logic [IW-1:0] pc_idx, pc_next_idx;
    logic [DW-1:0] addr_idx;
    logic [15:0]   f0_word, f1_word, r_word;
    logic          fetch_two;
    logic          prog_ok;
    logic          unused_hi;

    assign pc_idx      = pc_q[IW-1:0];
    assign pc_next_idx = pc_idx + IW'(1);
    assign addr_idx    = addr_q[DW-1:0];
    assign f0_word     = imem[pc_idx];
    assign f1_word     = imem[pc_next_idx];
    assign r_word      = dmem[addr_idx];
    assign fetch_two   = (f0_word[3:0] == I_TYPE_CODE) || (f0_word[3:0] == M_TYPE_CODE);
    assign prog_ok     = (state_q == S_IDLE) || (state_q == S_HALTED);
    assign unused_hi   = ^{pc_q[15:IW], addr_q[15:DW], bus.prog_addr[15:IW], bus.dbg_addr[15:DW]};

    assign bus.dbg_data = dmem[bus.dbg_addr[DW-1:0]];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.bus_pc)       state_d = S_PC_HI;
                else if (bus.bus_mar) state_d = S_A_HI;
                else if (bus.halt)    state_d = S_HALTED;
            end
            S_PC_HI:   state_d = S_F0L;
            S_F0L:     state_d = S_F0H;
            S_F0H:     state_d = fetch_two ? S_F1L : S_RECOVER;
            S_F1L:     state_d = S_F1H;
            S_F1H:     state_d = S_RECOVER;
            S_A_HI:    state_d = bus.bus_mdr ? S_W_L : S_R_L;
            S_R_L:     state_d = S_R_H;
            S_R_H:     state_d = S_RECOVER;
            S_W_L:     state_d = S_W_H;
            S_W_H:     state_d = S_RECOVER;
            S_RECOVER: state_d = S_IDLE;
            S_HALTED:  state_d = S_HALTED;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.bus_pc)       pc_q[7:0]   <= bus.out_bus;
                    else if (bus.bus_mar) addr_q[7:0] <= bus.out_bus;
                end
                S_PC_HI: pc_q[15:8]   <= bus.out_bus;
                S_A_HI:  addr_q[15:8] <= bus.out_bus;
                S_W_L:   lo_q         <= bus.out_bus;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus.prog_we && prog_ok)
            imem[bus.prog_addr[IW-1:0]] <= bus.prog_data;
    end

    // Write only on the final store byte, so a reset earlier in the store leaves dmem intact.
    always_ff @(posedge clk) begin
        if (rst && state_q == S_W_H)
            dmem[addr_idx] <= {bus.out_bus, lo_q};
    end

    always_comb begin
        bus.in_bus            = 8'h00;
        bus.ard_data_ready    = 1'b0;
        bus.ard_receive_ready = 1'b0;
        bus.halted            = 1'b0;
        if (rst) begin
            case (state_q)
                S_IDLE, S_RECOVER: bus.ard_receive_ready = 1'b1;
                S_F0L: begin bus.ard_data_ready = 1'b1; bus.in_bus = f0_word[7:0];  end
                S_F0H: begin bus.ard_data_ready = 1'b1; bus.in_bus = f0_word[15:8]; end
                S_F1L: begin bus.ard_data_ready = 1'b1; bus.in_bus = f1_word[7:0];  end
                S_F1H: begin bus.ard_data_ready = 1'b1; bus.in_bus = f1_word[15:8]; end
                S_R_L: begin bus.ard_data_ready = 1'b1; bus.in_bus = r_word[7:0];   end
                S_R_H: begin bus.ard_data_ready = 1'b1; bus.in_bus = r_word[15:8];  end
                S_HALTED: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_bus_memory.sv
// tb/tb_byte_bus_memory.sv - directed bench with a per-cycle transaction-level model of the byte bus endpoint
module tb_byte_bus_memory;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    byte_bus_memory_if bif ();

    byte_bus_memory #(
        .IMEM_DEPTH (16),
        .DMEM_DEPTH (16),
        .I_TYPE_CODE(4'h1),
        .M_TYPE_CODE(4'h2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    typedef struct packed {
        logic [7:0]  ib;
        logic        dr;
        logic        rr;
        logic        hl;
        logic        dv;
        logic [15:0] dbg;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] imem_m [16];
    logic [15:0] dmem_m [16];
    logic        dmem_known [16];
    exp_t        exp_q [$];
    logic [7:0]  got [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("in_bus", 16'(bif.in_bus), 16'(e.ib));
            chk("data_ready", 16'(bif.ard_data_ready), 16'(e.dr));
            chk("receive_ready", 16'(bif.ard_receive_ready), 16'(e.rr));
            chk("halted", 16'(bif.halted), 16'(e.hl));
            if (e.dv) chk("dbg_data", bif.dbg_data, e.dbg);
            if (bif.ard_data_ready) got.push_back(bif.in_bus);
        end
    end

    // One bus cycle: record what the outputs must be during it, then step past the next edge.
    task automatic cyc(input logic [7:0] ib, input logic dr, input logic rr, input logic hl);
        exp_t e;
        e.ib  = ib;
        e.dr  = dr;
        e.rr  = rr;
        e.hl  = hl;
        e.dv  = dmem_known[bif.dbg_addr[3:0]];
        e.dbg = dmem_m[bif.dbg_addr[3:0]];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [15:0] a, input logic [15:0] d);
        bif.prog_we = 1'b1; bif.prog_addr = a; bif.prog_data = d;
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        bif.prog_we = 1'b0;
        imem_m[a[3:0]] = d;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic with_mar);
        logic [15:0] w0, w1;
        logic [3:0]  i0;
        i0 = pc[3:0];
        w0 = imem_m[i0];
        w1 = imem_m[i0 + 4'd1];
        got.delete();
        bif.bus_pc = 1'b1; bif.bus_mar = with_mar; bif.out_bus = pc[7:0];
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        bif.bus_pc = 1'b0; bif.bus_mar = 1'b0; bif.out_bus = pc[15:8];
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        bif.out_bus = 8'h00;
        cyc(w0[7:0], 1'b1, 1'b0, 1'b0);
        cyc(w0[15:8], 1'b1, 1'b0, 1'b0);
        if (w0[3:0] == 4'h1 || w0[3:0] == 4'h2) begin
            cyc(w1[7:0], 1'b1, 1'b0, 1'b0);
            cyc(w1[15:8], 1'b1, 1'b0, 1'b0);
        end
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic load(input logic [15:0] a);
        logic [15:0] w;
        w = dmem_m[a[3:0]];
        got.delete();
        bif.bus_mar = 1'b1; bif.out_bus = a[7:0];
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        bif.bus_mar = 1'b0; bif.bus_mdr = 1'b0; bif.out_bus = a[15:8];
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        bif.out_bus = 8'h00;
        cyc(w[7:0], 1'b1, 1'b0, 1'b0);
        cyc(w[15:8], 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d, input logic poke);
        bif.bus_mar = 1'b1; bif.out_bus = a[7:0];
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        bif.bus_mar = 1'b0; bif.bus_mdr = 1'b1; bif.out_bus = a[15:8];
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        bif.bus_mdr = 1'b0; bif.out_bus = d[7:0];
        if (poke) begin
            bif.prog_we = 1'b1; bif.prog_addr = 16'h0007; bif.prog_data = 16'hDEAD;
        end
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        bif.prog_we = 1'b0; bif.out_bus = d[15:8];
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        dmem_m[a[3:0]]     = d;
        dmem_known[a[3:0]] = 1'b1;
        bif.out_bus = 8'h00;
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bif.bus_pc = 1'b0; bif.bus_mar = 1'b0; bif.bus_mdr = 1'b0; bif.halt = 1'b0;
        bif.out_bus = 8'h00; bif.prog_we = 1'b0; bif.prog_addr = 16'h0000;
        bif.prog_data = 16'h0000; bif.dbg_addr = 16'h0004;
        for (int i = 0; i < 16; i++) begin
            dmem_known[i] = 1'b0;
            dmem_m[i]     = 16'h0000;
            imem_m[i]     = 16'h0000;
        end

        rst = 1'b0;
        @(posedge clk); #1;
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        chk("reset_receive_ready", 16'(bif.ard_receive_ready), 16'h0001);

        prog(16'h0004, 16'h0A10);
        prog(16'h000F, 16'h0B01);
        prog(16'h0000, 16'h0005);
        prog(16'h0007, 16'h1234);
        prog(16'h0008, 16'h5672);
        prog(16'h0009, 16'h9ABC);

        fetch(16'h0004, 1'b0);
        chk("rtype_count", 16'(got.size()), 16'd2);
        chk("rtype_b0", 16'(got[0]), 16'h0010);
        chk("rtype_b1", 16'(got[1]), 16'h000A);

        fetch(16'h000F, 1'b0);
        chk("itype_count", 16'(got.size()), 16'd4);
        chk("itype_b1", 16'(got[1]), 16'h000B);
        chk("itype_wrap_b2", 16'(got[2]), 16'h0005);
        chk("itype_wrap_b3", 16'(got[3]), 16'h0000);

        fetch(16'h1238, 1'b0);
        chk("mtype_count", 16'(got.size()), 16'd4);
        chk("mtype_b0", 16'(got[0]), 16'h0072);
        chk("mtype_b3", 16'(got[3]), 16'h009A);

        store(16'h0004, 16'hFFFF, 1'b1);
        chk("store_dbg", bif.dbg_data, 16'hFFFF);
        load(16'h0004);
        chk("load_b0", 16'(got[0]), 16'h00FF);
        chk("load_b1", 16'(got[1]), 16'h00FF);

        store(16'h0023, 16'hBEEF, 1'b0);
        load(16'h0013);
        chk("load_mod_b0", 16'(got[0]), 16'h00EF);
        chk("load_mod_b1", 16'(got[1]), 16'h00BE);

        fetch(16'h0007, 1'b0);
        chk("prog_dropped_b0", 16'(got[0]), 16'h0034);
        chk("prog_dropped_b1", 16'(got[1]), 16'h0012);

        fetch(16'h0004, 1'b1);
        chk("pc_over_mar_count", 16'(got.size()), 16'd2);
        chk("pc_over_mar_b0", 16'(got[0]), 16'h0010);

        bif.bus_mar = 1'b1; bif.out_bus = 8'h04;
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        bif.bus_mar = 1'b0; bif.bus_mdr = 1'b1; bif.out_bus = 8'h00;
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        bif.bus_mdr = 1'b0; bif.out_bus = 8'h11; rst = 1'b0;
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; bif.out_bus = 8'h22;
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        bif.out_bus = 8'h00;
        chk("abort_store_dbg", bif.dbg_data, 16'hFFFF);

        bif.halt = 1'b1;
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        bif.halt = 1'b0;
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        chk("halted_flag", 16'(bif.halted), 16'h0001);
        got.delete();
        bif.bus_pc = 1'b1; bif.out_bus = 8'h04;
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        bif.bus_pc = 1'b0; bif.out_bus = 8'h00;
        repeat (5) cyc(8'h00, 1'b0, 1'b0, 1'b1);
        chk("halted_no_response", 16'(got.size()), 16'd0);
        rst = 1'b0;
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        fetch(16'h0004, 1'b0);
        chk("post_halt_b1", 16'(got[1]), 16'h000A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
